song_sequencer: RTL

//  Parametrised song-playback sequencer. Generates beat ticks from an internal tempo timer,

---
 rtl/song_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// Song-playback sequencer: tempo timer, beat ticks, shifter pulse and renderer handshake.
// Define SONG_LOOP_EN to make the song repeat until stopSong instead of ending in DONE.
module song_sequencer #(
    parameter int unsigned SONG_LEN    = 64,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned BEAT_PERIOD = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             startSong,
    input  logic             stopSong,
    input  logic             pause,
    input  logic             drawDone,
    output logic             shiftSong,
    output logic             beatIncremented,
    output logic             drawReq,
    output logic             songDone,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] songCounter
);

    localparam int unsigned TimerW = $clog2(BEAT_PERIOD);
    localparam logic [TimerW-1:0] TimerReload = TimerW'(BEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] SongLenC = CNT_W'(SONG_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBeat,
        StShift,
        StDraw,
        StWaitDraw,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               timer_run;
    logic               tick;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            timer_q   <= TimerReload;
            count_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        count_d         = count_q;
        pending_d       = pending_q;
        overrun_d       = overrun_q;
        shiftSong       = 1'b0;
        beatIncremented = 1'b0;
        drawReq         = 1'b0;
        songDone        = 1'b0;

        timer_run = state_q inside {StWaitBeat, StShift, StDraw, StWaitDraw};
        tick      = timer_run && (timer_q == '0) && !pause;

        if (timer_run && !pause) begin
            timer_d = tick ? TimerReload : timer_q - 1'b1;
        end
        // Only one beat of slack: a tick while pending is already set is simply lost.
        if (tick && (state_q != StWaitBeat)) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (startSong && !stopSong) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                count_d   = '0;
                timer_d   = TimerReload;
                overrun_d = 1'b0;
                pending_d = 1'b0;
                state_d   = StWaitBeat;
            end
            StWaitBeat: begin
                if (tick || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shiftSong = 1'b1;
                state_d   = StDraw;
            end
            StDraw: begin
                beatIncremented = 1'b1;
                count_d         = count_q + 1'b1;
                state_d         = StWaitDraw;
            end
            StWaitDraw: begin
                drawReq = 1'b1;
                if (drawDone) begin
                    if (count_q == SongLenC) begin
`ifdef SONG_LOOP_EN
                        songDone = 1'b1;
                        count_d  = '0;
                        state_d  = StWaitBeat;
`else
                        state_d  = StDone;
`endif
                    end else if (pending_q) begin
                        pending_d = 1'b0;
                        state_d   = StShift;
                    end else begin
                        state_d = StWaitBeat;
                    end
                end
            end
            StDone: begin
`ifndef SONG_LOOP_EN
                songDone = 1'b1;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over every transition; the beat count is frozen where it stood.
        if (stopSong && (state_q != StIdle)) begin
            state_d  = StIdle;
            count_d  = count_q;
            songDone = 1'b0;
        end
    end

    assign busy        = (state_q != StIdle);
    assign overrun     = overrun_q;
    assign songCounter = count_q;

endmodule
